// File: rtl/clk_chk_pkg.sv
// Shared types and constants for the clk_div_checker slice.
package clk_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } chk_state_t;

  localparam int unsigned ERR_CNT_W = 16;

  // Run length at which clk_div is declared stuck: more than a full period
  // without any transition.
  function automatic int unsigned stuck_thresh(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/clk_chk_sampler.sv
// Dual-edge capture of clk_div. Sample A is taken at negedge clk_in, sample B
// at posedge clk_in; both are presented together in the posedge domain, A being
// the older of the two.
module clk_chk_sampler (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_clk_div,
  output logic o_samp_a,
  output logic o_samp_b
);

  logic r_neg_a;
  logic r_pos_a;
  logic r_pos_b;

  // capture clk_div on the falling edge of the reference
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) r_neg_a <= 1'b0;
    else        r_neg_a <= i_clk_div;
  end

  // retime sample A and capture sample B on the rising edge
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_a <= 1'b0;
      r_pos_b <= 1'b0;
    end else begin
      r_pos_a <= r_neg_a;
      r_pos_b <= i_clk_div;
    end
  end

  assign o_samp_a = r_pos_a;
  assign o_samp_b = r_pos_b;

endmodule

// File: rtl/clk_div_checker.sv
// Divided-clock checker: measures high/low run lengths of clk_div in clk_in
// half-cycles, flags runs that differ from N, detects a stuck clk_div and
// reports lock after LOCK_PERIODS consecutive good periods.
// Optional build macro: CLK_DIV_CHECKER_ERRCNT_EN enables the saturating
// err_cnt counter; without it err_cnt is tied to zero.
//
// state  | meaning
// IDLE   | checker disabled, outputs cleared
// SEEK   | waiting for the first rising transition to align on a period
// CHECK  | checking runs, counting good periods toward lock
// LOCKED | LOCK_PERIODS good periods seen, still checking every run
module clk_div_checker
  import clk_chk_pkg::*;
#(
  parameter int N            = 7,
  parameter int W            = 5,
  parameter int LOCK_PERIODS = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clk_div,
  output logic                 locked,
  output logic                 err,
  output logic                 stuck_err,
  output logic [W-1:0]         hi_len,
  output logic [W-1:0]         lo_len,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int          GW        = $clog2(LOCK_PERIODS + 1);
  localparam int unsigned STUCK_INT = stuck_thresh(N);
  localparam logic [W-1:0]  N_LEN     = W'(N);
  localparam logic [W-1:0]  STUCK_LEN = W'(STUCK_INT);
  localparam logic [W-1:0]  RUN_ONE   = W'(1);
  localparam logic [W-1:0]  RUN_MAX   = {W{1'b1}};
  localparam logic [GW-1:0] LOCK_CNT  = GW'(LOCK_PERIODS);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);

  logic       w_samp_a;
  logic       w_samp_b;
  logic [1:0] w_samp;

  chk_state_t    r_state;
  logic [W-1:0]  r_run_len;
  logic          r_prev;
  logic [W-1:0]  r_hi_len;
  logic [W-1:0]  r_lo_len;
  logic [GW-1:0] r_good_cnt;
  logic          r_hi_ok;
  logic          r_locked;
  logic          r_err;
  logic          r_stuck;

  chk_state_t    w_state_nxt;
  logic [W-1:0]  w_run_nxt;
  logic          w_prev_nxt;
  logic [W-1:0]  w_hi_nxt;
  logic [W-1:0]  w_lo_nxt;
  logic [GW-1:0] w_good_nxt;
  logic          w_hi_ok_nxt;
  logic          w_err_nxt;
  logic          w_stuck_nxt;
  logic          w_bad;
  logic          w_rise;
  logic          w_chk;

  clk_chk_sampler u_sampler (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .i_clk_div (clk_div),
    .o_samp_a  (w_samp_a),
    .o_samp_b  (w_samp_b)
  );

  // index 0 is processed first (older sample A), then index 1 (sample B)
  assign w_samp = {w_samp_b, w_samp_a};

  // run tracking over both samples, then next-state and output decisions
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_len;
    w_prev_nxt  = r_prev;
    w_hi_nxt    = r_hi_len;
    w_lo_nxt    = r_lo_len;
    w_good_nxt  = r_good_cnt;
    w_hi_ok_nxt = r_hi_ok;
    w_err_nxt   = 1'b0;
    w_stuck_nxt = 1'b0;
    w_bad       = 1'b0;
    w_rise      = 1'b0;
    w_chk       = (r_state == ST_CHECK) || (r_state == ST_LOCKED);

    for (int i = 0; i < 2; i++) begin
      if (w_samp[i] == w_prev_nxt) begin
        if (w_run_nxt != RUN_MAX) w_run_nxt = w_run_nxt + RUN_ONE;
      end else begin
        if (w_samp[i]) w_rise = 1'b1;
        if (w_chk) begin
          if (w_prev_nxt) w_hi_nxt = w_run_nxt;
          else            w_lo_nxt = w_run_nxt;
          if (w_run_nxt != N_LEN) begin
            w_bad       = 1'b1;
            w_hi_ok_nxt = 1'b0;
            w_good_nxt  = '0;
          end else if (w_prev_nxt) begin
            w_hi_ok_nxt = 1'b1;
          end else begin
            // a good low run closes a period only if the high run before it was good
            if (w_hi_ok_nxt && (w_good_nxt != LOCK_CNT)) w_good_nxt = w_good_nxt + GOOD_ONE;
            w_hi_ok_nxt = 1'b0;
          end
        end
        w_run_nxt = RUN_ONE;
      end
      w_prev_nxt = w_samp[i];
    end

    case (r_state)
      ST_IDLE: begin
        w_run_nxt   = '0;
        w_hi_nxt    = '0;
        w_lo_nxt    = '0;
        w_good_nxt  = '0;
        w_hi_ok_nxt = 1'b0;
        if (en) w_state_nxt = ST_SEEK;
      end
      ST_SEEK: begin
        if (w_rise) begin
          w_state_nxt = ST_CHECK;
          w_good_nxt  = '0;
          w_hi_ok_nxt = 1'b0;
        end
      end
      ST_CHECK, ST_LOCKED: begin
        // run_len can step by two per cycle, so compare with >=
        if (w_run_nxt >= STUCK_LEN) begin
          w_stuck_nxt = 1'b1;
          w_state_nxt = ST_SEEK;
          w_good_nxt  = '0;
          w_hi_ok_nxt = 1'b0;
        end else if (w_bad) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_CHECK;
        end else if ((r_state == ST_CHECK) && (w_good_nxt == LOCK_CNT)) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_run_nxt   = '0;
      w_hi_nxt    = '0;
      w_lo_nxt    = '0;
      w_good_nxt  = '0;
      w_hi_ok_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_stuck_nxt = 1'b0;
    end
  end

  // state register and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_run_len  <= '0;
      r_prev     <= 1'b0;
      r_hi_len   <= '0;
      r_lo_len   <= '0;
      r_good_cnt <= '0;
      r_hi_ok    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_len  <= w_run_nxt;
      r_prev     <= w_prev_nxt;
      r_hi_len   <= w_hi_nxt;
      r_lo_len   <= w_lo_nxt;
      r_good_cnt <= w_good_nxt;
      r_hi_ok    <= w_hi_ok_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_err      <= w_err_nxt;
      r_stuck    <= w_stuck_nxt;
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign stuck_err = r_stuck;
  assign hi_len    = r_hi_len;
  assign lo_len    = r_lo_len;

`ifdef CLK_DIV_CHECKER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // saturating count of err and stuck_err pulses, updated with the pulse itself
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if ((w_err_nxt || w_stuck_nxt) && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker (N=7, W=5, LOCK_PERIODS=4). clk_div is
// driven as explicit run lengths, changing 1 ns after clk_in edges.
module tb_clk_div_checker;
  import clk_chk_pkg::*;

  localparam int N  = 7;
  localparam int W  = 5;
  localparam int LP = 4;

`ifdef CLK_DIV_CHECKER_ERRCNT_EN
  localparam int EXP_ERR_CNT = 3;
`else
  localparam int EXP_ERR_CNT = 0;
`endif

  logic          clk_in  = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          clk_div = 1'b0;
  logic          locked;
  logic          err;
  logic          stuck_err;
  logic [W-1:0]  hi_len;
  logic [W-1:0]  lo_len;
  logic [15:0]   err_cnt;

  int n_chk      = 0;
  int n_pass     = 0;
  int err_seen   = 0;
  int stuck_seen = 0;
  int both_chg   = 0;
  int cyc        = 0;
  int en_cyc     = 0;
  logic [W-1:0] hi_p = '0;
  logic [W-1:0] lo_p = '0;

  clk_div_checker #(.N(N), .W(W), .LOCK_PERIODS(LP)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .clk_div   (clk_div),
    .locked    (locked),
    .err       (err),
    .stuck_err (stuck_err),
    .hi_len    (hi_len),
    .lo_len    (lo_len),
    .err_cnt   (err_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  // pulse counters and same-cycle update detection, sampled mid-cycle
  always @(negedge clk_in) begin
    if (err) err_seen++;
    if (stuck_err) stuck_seen++;
    if ((hi_len != hi_p) && (lo_len != lo_p)) both_chg++;
    hi_p = hi_len;
    lo_p = lo_len;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic half_cyc();
    @(clk_in);
    #1;
  endtask

  task automatic drive_run(input logic lvl, input int len);
    clk_div = lvl;
    repeat (len) half_cyc();
  endtask

  task automatic drive_periods(input int k);
    repeat (k) begin
      drive_run(1'b1, N);
      drive_run(1'b0, N);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk_val("rst_locked", 32'(locked), 0);
    chk_val("rst_err", 32'(err), 0);
    chk_val("rst_stuck", 32'(stuck_err), 0);
    chk_val("rst_hi_len", 32'(hi_len), 0);
    chk_val("rst_lo_len", 32'(lo_len), 0);
    chk_val("rst_err_cnt", 32'(err_cnt), 0);

    @(negedge clk_in);
    #1;
    rst_n = 1'b1;

    // initial lock from a clean 7/7 divider
    en = 1'b1;
    en_cyc = cyc;
    drive_run(1'b0, N);
    drive_periods(LP);
    drive_run(1'b1, N);
    chk_val("lock_first", 32'(locked), 1);
    chk_val("lock_within_42", 32'((cyc - en_cyc) <= 42), 1);
    chk_val("lock_hi_len", 32'(hi_len), 7);
    chk_val("lock_lo_len", 32'(lo_len), 7);
    chk_val("lock_no_err", 32'(err_seen), 0);

    // one short high run
    drive_run(1'b0, N);
    drive_run(1'b1, 6);
    drive_run(1'b0, N);
    chk_val("short_err_once", 32'(err_seen), 1);
    chk_val("short_hi_len", 32'(hi_len), 6);
    chk_val("short_lo_len", 32'(lo_len), 7);
    chk_val("short_unlock", 32'(locked), 0);
    drive_periods(LP - 1);
    drive_run(1'b1, N);
    chk_val("relock_3_periods", 32'(locked), 0);
    drive_run(1'b0, N);
    drive_run(1'b1, N);
    chk_val("relock_4_periods", 32'(locked), 1);
    chk_val("relock_err_cnt_seen", 32'(err_seen), 1);

    // clk_div stuck high for 20 half-cycles
    drive_run(1'b0, N);
    drive_run(1'b1, 20);
    chk_val("stuck_once", 32'(stuck_seen), 1);
    chk_val("stuck_unlock", 32'(locked), 0);
    chk_val("stuck_state_seek", 32'(dut.r_state), 32'(ST_SEEK));
    chk_val("stuck_no_err", 32'(err_seen), 1);

    // 1-half-cycle low glitch sampled on a negedge inside a high run
    drive_run(1'b0, N);
    if (clk_in) drive_run(1'b0, 1);
    drive_run(1'b1, 5);
    drive_run(1'b0, 1);
    drive_run(1'b1, N);
    chk_val("glitch_err", 32'(err_seen), 2);
    chk_val("glitch_hi_len", 32'(hi_len), 5);
    chk_val("glitch_lo_len", 32'(lo_len), 1);
    chk_val("glitch_same_cycle", 32'(both_chg), 1);

    // relock, then drop en
    drive_run(1'b0, N);
    drive_periods(LP - 1);
    drive_run(1'b1, N);
    chk_val("glitch_relock", 32'(locked), 1);
    en = 1'b0;
    @(posedge clk_in);
    #1;
    chk_val("en0_locked", 32'(locked), 0);
    chk_val("en0_hi_len", 32'(hi_len), 0);
    chk_val("en0_lo_len", 32'(lo_len), 0);
    chk_val("en0_no_err", 32'(err_seen), 2);

    en = 1'b1;
    drive_run(1'b0, N);
    drive_periods(LP);
    drive_run(1'b1, N);
    chk_val("en1_relock", 32'(locked), 1);
    chk_val("en1_hi_len", 32'(hi_len), 7);
    chk_val("err_cnt_total", 32'(err_cnt), 32'(EXP_ERR_CNT));

    // asynchronous reset in the middle of a low run
    drive_run(1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk_val("arst_locked", 32'(locked), 0);
    chk_val("arst_err", 32'(err), 0);
    chk_val("arst_stuck", 32'(stuck_err), 0);
    chk_val("arst_hi_len", 32'(hi_len), 0);
    chk_val("arst_lo_len", 32'(lo_len), 0);
    chk_val("arst_err_cnt", 32'(err_cnt), 0);
    drive_run(1'b0, 2);
    rst_n = 1'b1;
    drive_run(1'b0, 3);
    drive_periods(LP);
    drive_run(1'b1, N);
    chk_val("restart_locked", 32'(locked), 1);
    chk_val("restart_no_err", 32'(err_seen), 2);
    chk_val("restart_no_stuck", 32'(stuck_seen), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
